// File: rtl/sqrt_iter.sv
// Multi-cycle unsigned integer square root, non-restoring, one root bit per cycle (+ optional fraction bits).
// Latency WIDTH/2+FRAC_WIDTH+2 cycles from go to a one-cycle done pulse; go must stay high or the op aborts.
module sqrt_iter #(
    parameter int WIDTH      = 32,
    parameter int FRAC_WIDTH = 0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             go,
    input  logic [WIDTH-1:0]                 in,
    output logic [WIDTH-1:0]                 out,
    output logic [WIDTH/2+FRAC_WIDTH:0]      rem,
    output logic                             done
);
    localparam int RW = WIDTH/2 + FRAC_WIDTH;
    localparam int AW = 2*RW;
    localparam int CW = $clog2(RW) + 1;

    if (WIDTH < 2 || (WIDTH % 2) != 0 || FRAC_WIDTH < 0 || FRAC_WIDTH > WIDTH/2) begin : g_bad_param
        $error("sqrt_iter: illegal WIDTH/FRAC_WIDTH combination");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIX, ST_DONE} state_t;

    state_t          state;
    logic [AW-1:0]   a;
    logic [RW-1:0]   q;
    logic [RW+1:0]   r;
    logic [CW-1:0]   cnt;

    logic [RW+1:0]   left;
    logic [RW+1:0]   right;
    logic [RW+1:0]   r_step;
    logic [RW:0]     q_shift;
    logic [RW+1:0]   r_fix;
    logic [WIDTH-1:0] out_n;

    // Sign of the partial remainder selects add vs. subtract; the new root bit is its complement.
    always_comb begin
        left    = {r[RW-1:0], a[AW-1 -: 2]};
        right   = {q, r[RW+1], 1'b1};
        r_step  = r[RW+1] ? (left + right) : (left - right);
        q_shift = {q, ~r_step[RW+1]};
        r_fix   = r[RW+1] ? (r + {1'b0, q, 1'b1}) : r;
        out_n   = '0;
        out_n[RW-1:0] = q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            a     <= '0;
            q     <= '0;
            r     <= '0;
            cnt   <= '0;
            out   <= '0;
            rem   <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (go) begin
                        a     <= AW'(in) << (2*FRAC_WIDTH);
                        q     <= '0;
                        r     <= '0;
                        cnt   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!go) begin
                        state <= ST_IDLE;
                    end else begin
                        r   <= r_step;
                        q   <= q_shift[RW-1:0];
                        a   <= a << 2;
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(RW-1))
                            state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (!go) begin
                        state <= ST_IDLE;
                    end else begin
                        r     <= r_fix;
                        out   <= out_n;
                        rem   <= r_fix[RW:0];
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sqrt_iter.sv
// Bench for sqrt_iter: 32-bit integer instance and 8-bit instance with 4 fractional root bits.
module tb_sqrt_iter;
    logic        clk = 1'b0;
    logic        reset;
    logic        go32, go8;
    logic [31:0] in32, out32;
    logic [16:0] rem32;
    logic        done32;
    logic [7:0]  in8, out8;
    logic [8:0]  rem8;
    logic        done8;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    sqrt_iter #(.WIDTH(32), .FRAC_WIDTH(0)) dut32 (
        .clk(clk), .reset(reset), .go(go32), .in(in32),
        .out(out32), .rem(rem32), .done(done32)
    );
    sqrt_iter #(.WIDTH(8), .FRAC_WIDTH(4)) dut8 (
        .clk(clk), .reset(reset), .go(go8), .in(in8),
        .out(out8), .rem(rem8), .done(done8)
    );

    typedef struct {
        int     sel;
        longint x;
        longint exp_out;
        longint exp_rem;
    } vec_t;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic longint isqrt(input longint x);
        longint rr = 0;
        for (int b = 31; b >= 0; b--) begin
            longint t = rr | (longint'(1) << b);
            if (t * t <= x) rr = t;
        end
        return rr;
    endfunction

    // Starts an op at post-edge time, garbles in after the load edge, waits for done,
    // checks result/latency and that done lasts a single cycle. go is left high.
    task automatic do_op(input int sel, input longint x, input longint eo, input longint er,
                         input int exp_lat, input string nm);
        int   n = 0;
        logic seen = 1'b0;
        if (sel == 0) begin in32 = x[31:0]; go32 = 1'b1; end
        else          begin in8  = x[7:0];  go8  = 1'b1; end
        while (!seen && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) begin
                if (sel == 0) in32 = ~in32; else in8 = ~in8;
            end
            seen = (sel == 0) ? done32 : done8;
        end
        chk({nm, "_done_seen"}, longint'(seen), 1);
        if (seen) begin
            chk({nm, "_out"}, (sel == 0) ? longint'(out32) : longint'(out8), eo);
            chk({nm, "_rem"}, (sel == 0) ? longint'(rem32) : longint'(rem8), er);
            if (exp_lat > 0) chk({nm, "_latency"}, n, exp_lat);
            @(posedge clk); #1;
            chk({nm, "_done_width"}, (sel == 0) ? longint'(done32) : longint'(done8), 0);
        end
    endtask

    vec_t vecs[$];

    initial begin
        int pulses;
        longint x;
        reset = 1'b1; go32 = 1'b0; go8 = 1'b0; in32 = '0; in8 = '0;

        vecs.push_back('{0, 0, 0, 0});
        vecs.push_back('{0, 144, 12, 0});
        vecs.push_back('{0, 64'hFFFF_FFFF, 65535, 131070});
        vecs.push_back('{0, 1, 1, 0});
        vecs.push_back('{0, 2, 1, 1});
        vecs.push_back('{0, 99, 9, 18});
        vecs.push_back('{0, 1000000, 1000, 0});
        vecs.push_back('{1, 2, 22, 28});
        vecs.push_back('{1, 255, 255, 255});
        vecs.push_back('{1, 0, 0, 0});
        vecs.push_back('{1, 1, 16, 0});
        vecs.push_back('{1, 3, 27, 39});
        vecs.push_back('{1, 100, 160, 0});

        #12;
        chk("reset_out32", out32, 0);
        chk("reset_rem32", rem32, 0);
        chk("reset_done32", done32, 0);
        chk("reset_out8", out8, 0);
        chk("reset_done8", done8, 0);
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;

        // Table: each op starts from IDLE with go low beforehand.
        foreach (vecs[i]) begin
            do_op(vecs[i].sel, vecs[i].x, vecs[i].exp_out, vecs[i].exp_rem,
                  (vecs[i].sel == 0) ? 18 : 10, $sformatf("vec%0d", i));
            go32 = 1'b0; go8 = 1'b0;
            @(posedge clk); #1;
        end

        // Back-to-back: go held high across DONE, second op loads in the following IDLE cycle.
        do_op(0, 144, 12, 0, 18, "b2b_first");
        do_op(0, 64'hFFFF_FFFF, 65535, 131070, 18, "b2b_second");
        go32 = 1'b0;
        @(posedge clk); #1;

        // Abort: go drops after 5 edges; no done, previous result retained.
        go32 = 1'b1; in32 = 32'd12345;
        repeat (5) @(posedge clk);
        #1 go32 = 1'b0;
        pulses = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done32) pulses++;
        end
        chk("abort_no_done", pulses, 0);
        chk("abort_out_held", out32, 65535);
        chk("abort_rem_held", rem32, 131070);
        do_op(0, 12345, 111, 24, 18, "after_abort");
        go32 = 1'b0;
        @(posedge clk); #1;

        // Async reset between edges mid-RUN.
        go32 = 1'b1; in32 = 32'd50000;
        repeat (6) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_out32", out32, 0);
        chk("arst_rem32", rem32, 0);
        chk("arst_done32", done32, 0);
        chk("arst_out8", out8, 0);
        go32 = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;
        do_op(0, 50000, 223, 271, 18, "after_reset");
        go32 = 1'b0;
        @(posedge clk); #1;

        // Random ops against a bit-by-bit integer sqrt model.
        for (int k = 0; k < 60; k++) begin
            x = longint'($urandom());
            do_op(0, x, isqrt(x), x - isqrt(x) * isqrt(x), 18, "rand32");
            go32 = 1'b0;
            @(posedge clk); #1;
            x = longint'($urandom_range(0, 255));
            do_op(1, x, isqrt(x << 8), (x << 8) - isqrt(x << 8) * isqrt(x << 8), 10, "rand8");
            go8 = 1'b0;
            @(posedge clk); #1;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
